// File: rtl/bcd_encoder_seq_if.sv
// Handshake/data bundle between the stopwatch counter (master) and the
// sequential binary-to-BCD encoder (slave).
interface bcd_encoder_seq_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bcd_encoder_seq.sv
// Sequential binary-to-BCD encoder (double dabble), one input bit per clock.
// Result digit 0 (bcd[3:0]) is the least significant decimal digit.
module bcd_encoder_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_encoder_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_int_q, ovf_int_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             overflow_q, overflow_d;
    logic [BCD_W-1:0] adj;

    // Add-3 correction: every digit >= 5 gets +3, no carry between digits
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                      : work_q[4*i +: 4];
        end
    end

    // Next-state logic for the conversion FSM and result registers
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_int_d  = ovf_int_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shreg_d   = bus.bin;
                    work_d    = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    ovf_int_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Bit leaving the top digit means the value needs more digits
                // than we have; it is remembered as a sticky overflow.
                work_d    = {adj[BCD_W-2:0], shreg_q[BIN_W-1]};
                shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
                ovf_int_d = ovf_int_q | adj[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Results are loaded on the edge into FINISH so that
                    // done and the new bcd/overflow are visible together.
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (ovf_int_d) begin
                        bcd_d      = {DIGITS{4'h9}};
                        overflow_d = 1'b1;
                    end else begin
                        bcd_d      = work_d;
                        overflow_d = 1'b0;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_int_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_int_q  <= ovf_int_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = overflow_q;
endmodule

// File: doc/bcd_encoder_seq.md
Name: bcd_encoder_seq

Overview:
Sequential binary-to-BCD encoder using shift-and-add-3 (double dabble), one bit per clock. It converts the stopwatch binary time count into packed BCD digits. The scan logic then presents those digits one at a time to the segment decoder. It is the encoding end of the BCD digit interface that the 7-segment decoder consumes.

Parameters:
BIN_W, 27, width of binary input (27 bits covers 99,999,999).
DIGITS, 8, number of BCD output digits (one per display anode).

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled only in IDLE
bin  input  BIN_W  binary value, captured on accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd/overflow are updated
bcd  output  4*DIGITS  packed BCD result; digit 0 = bcd[3:0] = least significant, maps to anum 0
overflow  output  1  captured bin exceeded 10^DIGITS-1; bcd saturated

Behaviour:
- Reset (rst_n low, asynchronous, any state): FSM -> IDLE.
  - busy=0, done=0, bcd=0, overflow=0.
  - Working registers and bit counter cleared.
- Outputs are registered. bcd and overflow hold the last result until the next done.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE: on start=1 at edge T:
  - capture bin into shift register.
  - clear BCD working register (4*DIGITS bits).
  - load bit counter = BIN_W.
  - go to SHIFT; busy=1 from T+1.
- SHIFT, each cycle:
  - Every working digit >= 5 gets +3 (4-bit add, no carry between digits).
  - Then {work, shreg} shifts left by 1; shreg MSB enters work LSB.
  - Counter decrements. After the BIN_W-th shift, go to FINISH.
  - SHIFT occupies exactly BIN_W cycles.
- Working-register overflow:
  - Any bit shifted out of work MSB sets a sticky ovf_int.
  - The work register is 4*DIGITS bits, so an overflowing value has no valid BCD representation.
- FINISH (one cycle):
  - If ovf_int=0: bcd <= work, overflow <= 0.
  - If ovf_int=1: bcd <= all digits 4'h9, overflow <= 1.
  - done=1 for this cycle only, busy=0, return to IDLE.
- Latency: start accepted at edge T -> done high in cycle T+BIN_W+1 (T+28 at defaults).
  - Back-to-back: start may be reasserted in the cycle after done; the next result follows 28 cycles later.
- start while busy or in FINISH: ignored, not queued. bin changes after capture have no effect.
- Every digit of a non-overflow result is 0..9.
- Reset mid-conversion: abort immediately, no done pulse, outputs return to reset values.

Test Plan:
1. Reset, then start with bin=0 -> busy high 27 cycles; done at T+28; bcd=32'h00000000, overflow=0.
2. bin=12345678 -> bcd=32'h12345678, overflow=0. Digit 0 = 4'h8, digit 7 = 4'h1.
3. Boundaries:
   - bin=99999999 -> bcd=32'h99999999, overflow=0.
   - bin=100000000 -> bcd=32'h99999999, overflow=1.
   - bin=2^27-1 -> bcd=32'h99999999, overflow=1.
4. Input changes while busy:
   - Start bin=42, then pulse start with bin=7 at cycle T+5 -> single done at T+28 with bcd=32'h00000042.
   - Changing bin during SHIFT does not alter the result.
5. Reset mid-conversion:
   - Start bin=555, assert rst_n=0 at T+10 -> busy=0, bcd=0 immediately (asynchronously); no done.
   - New start after release with bin=9 -> bcd=32'h00000009.
6. Back-to-back and scoreboard:
   - start bin=59, start again the cycle after done with bin=60 -> results 32'h00000059 then 32'h00000060, each with a one-cycle done.
   - 1000 random bin values vs. a reference model.
